// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the two-digit BCD countdown timer: controller states,
// BCD digit limit, prescaler width and the load-time digit clamp.
package bcd_timer_pkg;

  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam int unsigned PRESC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_e;

  // Out-of-range nibbles (A..F) are shown as the largest legal digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    if (d > BCD_MAX) begin
      return BCD_MAX;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD decade that loads a clamped digit and counts down with borrow.
// borrow_out flags that this decade is wrapping 0 -> 9 on the current enable.
module bcd_digit_down
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       dec_en,
  output logic [3:0] q,
  output logic       borrow_out
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value: load wins over decrement.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = bcd_clamp(din);
    end else if (dec_en) begin
      q_d = (q_q == 4'd0) ? BCD_MAX : (q_q - 4'd1);
    end else begin
      q_d = q_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = dec_en & (q_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with load/start/pause control, a TICK_DIV
// prescaler and a one-cycle done pulse when the count reaches 00.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       done
);

  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 32'd1);

  timer_state_e       state_q;
  logic [PRESC_W-1:0] presc_q;
  logic               running_q;
  logic               done_q;

  logic [3:0] tens_s;
  logic [3:0] ones_s;
  logic       ones_borrow_s;
  logic       tens_borrow_s;
  logic       tick_s;
  logic       ones_dec_s;
  logic       count_zero_s;
  logic       count_one_s;

  assign count_zero_s = (tens_s == 4'd0) && (ones_s == 4'd0);
  assign count_one_s  = (tens_s == 4'd0) && (ones_s == 4'd1);
  assign ones_dec_s   = tick_s & ~count_zero_s;

  // A countdown step happens only on an undisturbed RUN cycle where the prescaler wraps.
  always_comb begin
    tick_s = 1'b0;
    if ((state_q == ST_RUN) && !load && !pause && (presc_q == TICK_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  bcd_digit_down u_ones (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .din        (load_val[3:0]),
    .dec_en     (ones_dec_s),
    .q          (ones_s),
    .borrow_out (ones_borrow_s)
  );

  bcd_digit_down u_tens (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .din        (load_val[7:4]),
    .dec_en     (ones_borrow_s),
    .q          (tens_s),
    .borrow_out (tens_borrow_s)
  );

  // Controller: state, prescaler and the registered running/done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        state_q   <= ST_IDLE;
        presc_q   <= '0;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (count_zero_s) begin
                state_q <= ST_EXPIRED;
                done_q  <= 1'b1;
              end else begin
                state_q   <= ST_RUN;
                presc_q   <= '0;
                running_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (pause) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end else if (presc_q == TICK_LAST) begin
              presc_q <= '0;
              // A tens borrow here would be an underflow; expire rather than wrap.
              if (count_one_s || tens_borrow_s) begin
                state_q   <= ST_EXPIRED;
                running_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end else begin
              presc_q <= presc_q + 8'd1;
            end
          end
          ST_PAUSE: begin
            if (start && !pause) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_EXPIRED: begin
            running_q <= 1'b0;
          end
          default: begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tens    = tens_s;
  assign ones    = ones_s;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench: two timers (TICK_DIV=2 and TICK_DIV=1) share stimulus
// and are compared against a cycle-count reference model, directed vectors and sequences.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       pause;
  logic [3:0] tens2, ones2, tens1, ones1;
  logic       running2, done2, running1, done1;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.TICK_DIV(2)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tens(tens2), .ones(ones2), .running(running2), .done(done2)
  );

  bcd_countdown_timer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tens(tens1), .ones(ones1), .running(running1), .done(done1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: count = loaded value minus completed steps, where a step
  // is every m_div-th un-paused RUN cycle since the last load.
  typedef enum int {M_IDLE, M_COUNTING, M_HELD, M_FINISHED} mmode_e;
  mmode_e m_mode[2];
  int     m_loaded[2];
  int     m_run[2];
  int     m_div[2];
  bit     m_done[2];

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       ps;
    int         et;
    int         eo;
    logic       er;
    logic       ed;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k]   = M_IDLE;
      m_loaded[k] = 0;
      m_run[k]    = 0;
      m_done[k]   = 1'b0;
    end
  endtask

  task automatic model_edge(input int k);
    int t;
    int o;
    m_done[k] = 1'b0;
    if (load) begin
      t = int'(load_val[7:4]);
      o = int'(load_val[3:0]);
      if (t > 9) t = 9;
      if (o > 9) o = 9;
      m_loaded[k] = t * 10 + o;
      m_run[k]    = 0;
      m_mode[k]   = M_IDLE;
    end else begin
      case (m_mode[k])
        M_IDLE: if (start) begin
          if (m_loaded[k] - m_run[k] / m_div[k] == 0) begin
            m_mode[k] = M_FINISHED;
            m_done[k] = 1'b1;
          end else begin
            m_mode[k] = M_COUNTING;
          end
        end
        M_COUNTING: if (pause) begin
          m_mode[k] = M_HELD;
        end else begin
          m_run[k]++;
          if (m_loaded[k] - m_run[k] / m_div[k] == 0) begin
            m_mode[k] = M_FINISHED;
            m_done[k] = 1'b1;
          end
        end
        M_HELD: if (start && !pause) m_mode[k] = M_COUNTING;
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input int k, input logic [3:0] at, input logic [3:0] ao,
                             input logic ar, input logic ad);
    int c;
    c = m_loaded[k] - m_run[k] / m_div[k];
    check($sformatf("model%0d_tens", k), int'(at), c / 10);
    check($sformatf("model%0d_ones", k), int'(ao), c % 10);
    check($sformatf("model%0d_running", k), int'(ar), (m_mode[k] == M_COUNTING) ? 1 : 0);
    check($sformatf("model%0d_done", k), int'(ad), int'(m_done[k]));
  endtask

  task automatic check_both();
    check_model(0, tens2, ones2, running2, done2);
    check_model(1, tens1, ones1, running1, done1);
  endtask

  task automatic set_in(input logic l, input logic [7:0] lv, input logic s, input logic p);
    load = l; load_val = lv; start = s; pause = p;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic add(input logic ld, input logic [7:0] lv, input logic st, input logic ps,
                     input int et, input int eo, input logic er, input logic ed);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.ps = ps;
    v.et = et; v.eo = eo; v.er = er; v.ed = ed;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    m_div[0] = 2;
    m_div[1] = 1;
    model_reset();
    reset = 1'b1;
    set_in(1'b0, 8'h00, 1'b0, 1'b0);

    // TICK_DIV=2 directed vectors: {load, load_val, start, pause} -> {tens, ones, running, done}
    add(1, 8'h03, 0, 0, 0, 3, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3, 1, 0);
    add(0, 8'h00, 0, 0, 0, 3, 1, 0);
    add(0, 8'h00, 0, 0, 0, 2, 1, 0);
    add(0, 8'h00, 0, 0, 0, 2, 1, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 1);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0);
    add(1, 8'hFA, 0, 0, 9, 9, 0, 0);
    add(0, 8'h00, 1, 0, 9, 9, 1, 0);
    add(0, 8'h00, 1, 1, 9, 9, 0, 0);
    add(0, 8'h00, 0, 1, 9, 9, 0, 0);
    add(0, 8'h00, 1, 0, 9, 9, 1, 0);
    add(0, 8'h00, 0, 0, 9, 9, 1, 0);
    add(0, 8'h00, 0, 0, 9, 8, 1, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0, 1);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(1, 8'h10, 0, 0, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 0, 1, 0);
    add(0, 8'h00, 0, 0, 0, 9, 1, 0);
    add(0, 8'h00, 1, 0, 0, 9, 1, 0);
    add(0, 8'h00, 0, 0, 0, 8, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_tens", int'(tens2), 0);
    check("reset_ones", int'(ones2), 0);
    check("reset_running", int'(running2), 0);
    check("reset_done", int'(done2), 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      set_in(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].ps);
      step();
      check($sformatf("vec%0d_tens", i), int'(tens2), vecs[i].et);
      check($sformatf("vec%0d_ones", i), int'(ones2), vecs[i].eo);
      check($sformatf("vec%0d_running", i), int'(running2), int'(vecs[i].er));
      check($sformatf("vec%0d_done", i), int'(done2), int'(vecs[i].ed));
      check_model(1, tens1, ones1, running1, done1);
    end

    // Borrow run continues: 4 RUN cycles used, 16 more to reach 00.
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      n++;
      check_both();
      if (done2) break;
    end
    check("borrow_cycles_to_done", n, 16);

    // Pause/resume: pause sampled 3 cycles into RUN, hold, then resume.
    set_in(1'b1, 8'h05, 1'b0, 1'b0); step();
    set_in(1'b0, 8'h00, 1'b1, 1'b0); step();
    set_in(1'b0, 8'h00, 1'b0, 1'b0); step(); step();
    set_in(1'b0, 8'h00, 1'b0, 1'b1); step();
    check("pause_ones", int'(ones2), 4);
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      check("pause_hold_ones", int'(ones2), 4);
      check("pause_hold_running", int'(running2), 0);
    end
    set_in(1'b0, 8'h00, 1'b1, 1'b0); step();
    check_both();
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      n++;
      check_both();
      if (done2) break;
    end
    check("resume_cycles_to_done", n, 8);

    // Reset between edges mid-run: immediate clear and no done pulse afterwards.
    set_in(1'b1, 8'h50, 1'b0, 1'b0); step();
    set_in(1'b0, 8'h00, 1'b1, 1'b0); step();
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (5) step();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_tens", int'(tens2), 0);
    check("midrst_ones", int'(ones2), 0);
    check("midrst_running", int'(running2), 0);
    check("midrst_done", int'(done2), 0);
    check("midrst_running1", int'(running1), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      check("postrst_no_done", int'(done2), 0);
      check_both();
    end

    // TICK_DIV=1: one step per cycle, done on the 2nd cycle after RUN entry.
    set_in(1'b1, 8'h02, 1'b0, 1'b0); step();
    set_in(1'b0, 8'h00, 1'b1, 1'b0); step();
    check("div1_run_ones", int'(ones1), 2);
    check("div1_running", int'(running1), 1);
    set_in(1'b0, 8'h00, 1'b0, 1'b0); step();
    check("div1_ones_1", int'(ones1), 1);
    check("div1_done_early", int'(done1), 0);
    step();
    check("div1_ones_0", int'(ones1), 0);
    check("div1_done", int'(done1), 1);
    step();
    check("div1_done_once", int'(done1), 0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      load     = ($urandom % 12) == 0;
      load_val = (($urandom % 3) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
      start    = ($urandom % 3) == 0;
      pause    = ($urandom % 7) == 0;
      step();
      check_both();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 The module SHALL provide parameter TICK_DIV, default 10, the number of clk cycles per countdown step; legal range 1..255.
REQ-002 The module SHALL provide port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The module SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL provide port load, input, 1 bit: load load_val into the counter.
REQ-005 The module SHALL provide port load_val, input, 8 bits: [7:4] tens BCD, [3:0] ones BCD.
REQ-006 The module SHALL provide port start, input, 1 bit: begin or resume the countdown.
REQ-007 The module SHALL provide port pause, input, 1 bit: suspend the countdown.
REQ-008 The module SHALL provide port tens, output, 4 bits: current tens digit, BCD.
REQ-009 The module SHALL provide port ones, output, 4 bits: current ones digit, BCD.
REQ-010 The module SHALL provide port running, output, 1 bit: high while the state is RUN.
REQ-011 The module SHALL provide port done, output, 1 bit: one-cycle pulse on expiry.

Function
REQ-012 The controller SHALL implement four states: IDLE, RUN, PAUSE and EXPIRED.
REQ-013 When load is sampled high in any state, the controller SHALL capture load_val, clear the prescaler and enter IDLE on the next edge; load SHALL have priority over start and pause.
REQ-014 On load, any digit above 9 SHALL be clamped to 9 (e.g. 0xAF loads as 99).
REQ-015 Start in IDLE with a nonzero count SHALL enter RUN on the next edge, with the prescaler at 0.
REQ-016 Start in IDLE with count 00 SHALL enter EXPIRED and pulse done for one cycle.
REQ-017 In RUN, the prescaler SHALL count 0..TICK_DIV-1, and the count SHALL decrement by 1 on the edge where the prescaler wraps; the first decrement lands TICK_DIV cycles after RUN is entered.
REQ-018 Decrement SHALL follow BCD borrow rules: ones 0 becomes 9 and tens decrements; otherwise ones decrements.
REQ-019 The count SHALL never wrap below 00.
REQ-020 On the edge where the count becomes 00, the state SHALL become EXPIRED and done SHALL be high for exactly that following cycle.
REQ-021 Pause in RUN SHALL enter PAUSE and freeze both the count and the prescaler.
REQ-022 Start in PAUSE SHALL resume RUN from the frozen prescaler value.
REQ-023 If start and pause are high together in RUN or PAUSE, pause SHALL win.
REQ-024 In EXPIRED, the count SHALL hold 00, and start and pause SHALL be ignored; only load or reset leaves EXPIRED.
REQ-025 Start in RUN, pause in IDLE, and pause in PAUSE SHALL have no effect.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 Asserting reset SHALL immediately force the state to IDLE, tens=0, ones=0, the prescaler to 0, running=0 and done=0, regardless of the clock.
REQ-028 Reset asserted mid-RUN SHALL abort the countdown and produce no done pulse.
REQ-029 After reset deasserts, the module SHALL respond to inputs from the first following rising edge.

Structure
REQ-030 The state encoding (IDLE/RUN/PAUSE/EXPIRED) and the BCD_MAX=9 constant SHALL reside in the shared package bcd_timer_pkg.
REQ-031 A single-decade sub-module bcd_digit_down SHALL be used, instantiated twice and chained ones-to-tens.
REQ-032 bcd_digit_down SHALL provide ports clk, reset, load, din[3:0], dec_en, q[3:0] and borrow_out, with borrow_out = dec_en AND q==0.
REQ-033 The prescaler width SHALL be 8 bits.

Verification (TICK_DIV=2 unless noted)
REQ-034 Basic countdown: load 0x03, then start -> ones steps 3,2,1,0 every 2 cycles, done pulses once, running falls, EXPIRED holds 00.
REQ-035 Borrow: load 0x10, start -> after 2 cycles tens=0, ones=9; count reaches 00 after 20 cycles of RUN.
REQ-036 Pause/resume: load 0x05, start, pause after 3 cycles -> count holds 4 for 10 cycles; start -> count reaches 00 at the expected cumulative time, with no skipped or extra steps.
REQ-037 Edge cases: load 0x00 then start -> done pulse next cycle; load 0xFA -> 99 displayed; start and pause together in RUN -> PAUSE.
REQ-038 Reset mid-run: load 0x50, start, assert reset between clock edges -> outputs are 0 immediately and done never pulses.
REQ-039 TICK_DIV=1: load 0x02, start -> decrements every cycle, done on the 2nd cycle after RUN is entered.
